// File: rtl/cva6_cfg_dump.sv
// Configuration read-back block: packs the elaborated core configuration into an 8-word table
// and serves it both as a valid/ready stream dump and as a 1-cycle random-access read port.

package cva6_cfg_dump_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned VLEN;
        int unsigned PLEN;
        int unsigned GPLEN;
        bit          RVA;
        bit          RVB;
        bit          RVC;
        bit          RVD;
        bit          RVF;
        bit          RVH;
        bit          RVS;
        bit          RVU;
        bit          RVV;
        bit          RVZCB;
        bit          RVZCMP;
        bit          RVZCMT;
        bit          RVZiCond;
        bit          RVZicntr;
        bit          RVZihpm;
        bit          ZKN;
        bit          XF16;
        bit          XF16ALT;
        bit          XF8;
        bit          XFVec;
        bit          CvxifEn;
        bit          SuperscalarEn;
        bit          MmuPresent;
        bit          DebugEn;
        int unsigned NR_SB_ENTRIES;
        int unsigned NrCommitPorts;
        int unsigned NrIssuePorts;
        int unsigned NrWbPorts;
        int unsigned NrRgprPorts;
        int unsigned NUM_THREADS;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned InstrTlbEntries;
        int unsigned DataTlbEntries;
        int unsigned NrPMPEntries;
        int unsigned FETCH_WIDTH;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

module cva6_cfg_dump
    import cva6_cfg_dump_pkg::*;
#(
    parameter cva6_cfg_t  CVA6Cfg = cva6_cfg_empty,
    parameter logic [7:0] Version = 8'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic [2:0]  index_o,
    output logic        last_o,
    output logic        busy_o,
    input  logic        rd_req_i,
    input  logic [3:0]  rd_addr_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        rd_err_o
);

    // Every field is cut down to its slot width; word 7 is a checksum over words 0..6.
    function automatic logic [7:0][31:0] build_table(input cva6_cfg_t cfg, input logic [7:0] ver);
        logic [7:0][31:0] t;
        t    = '0;
        t[0] = {8'hCF, 8'hA6, 8'h00, ver};
        t[1] = {cfg.XLEN[7:0], cfg.VLEN[7:0], cfg.PLEN[7:0], cfg.GPLEN[7:0]};
        t[2] = {8'h00,
                cfg.DebugEn, cfg.MmuPresent, cfg.SuperscalarEn, cfg.CvxifEn,
                cfg.XFVec, cfg.XF8, cfg.XF16ALT, cfg.XF16,
                cfg.ZKN, cfg.RVZihpm, cfg.RVZicntr, cfg.RVZiCond,
                cfg.RVZCMT, cfg.RVZCMP, cfg.RVZCB, cfg.RVV,
                cfg.RVU, cfg.RVS, cfg.RVH, cfg.RVF,
                cfg.RVD, cfg.RVC, cfg.RVB, cfg.RVA};
        t[3] = {cfg.NR_SB_ENTRIES[7:0], cfg.NrCommitPorts[3:0], cfg.NrIssuePorts[3:0],
                cfg.NrWbPorts[3:0], cfg.NrRgprPorts[3:0], cfg.NUM_THREADS[7:0]};
        t[4] = {cfg.ICACHE_SET_ASSOC[7:0], cfg.ICACHE_INDEX_WIDTH[7:0], cfg.ICACHE_LINE_WIDTH[15:0]};
        t[5] = {cfg.DCACHE_SET_ASSOC[7:0], cfg.DCACHE_INDEX_WIDTH[7:0], cfg.DCACHE_LINE_WIDTH[15:0]};
        t[6] = {cfg.InstrTlbEntries[7:0], cfg.DataTlbEntries[7:0], cfg.NrPMPEntries[7:0],
                cfg.FETCH_WIDTH[7:0]};
        t[7] = t[0] ^ t[1] ^ t[2] ^ t[3] ^ t[4] ^ t[5] ^ t[6];
        return t;
    endfunction

    localparam logic [7:0][31:0] CfgTable = build_table(CVA6Cfg, Version);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Abort outranks acceptance, and start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_o = 1'b0;
        data_o  = '0;
        index_o = '0;
        last_o  = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                valid_o = 1'b1;
                data_o  = CfgTable[idx_q];
                index_o = idx_q;
                last_o  = (idx_q == 3'd7);
                busy_o  = 1'b1;
                if (abort_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (ready_i) begin
                    if (idx_q == 3'd7) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    logic        rd_valid_q;
    logic        rd_err_q;
    logic [31:0] rd_data_q;

    // Out-of-range addresses answer with an error flag and zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req_i;
            rd_err_q   <= rd_req_i & rd_addr_i[3];
            rd_data_q  <= (rd_req_i && !rd_addr_i[3]) ? CfgTable[rd_addr_i[2:0]] : '0;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_cva6_cfg_dump.sv
// Scoreboard bench for cva6_cfg_dump: stimulus queues hand-computed table words, a negedge
// monitor compares every presented stream beat and read response against the queues.

module tb_cva6_cfg_dump;
    import cva6_cfg_dump_pkg::*;

    // cv64a6-like build; NUM_THREADS=257 exercises slot truncation (keeps 8'h01).
    localparam cva6_cfg_t TbCfg = '{
        XLEN: 64, VLEN: 64, PLEN: 56, GPLEN: 41,
        RVA: 1'b1, RVB: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVH: 1'b0, RVS: 1'b1, RVU: 1'b1,
        RVV: 1'b0, RVZCB: 1'b1, RVZCMP: 1'b0, RVZCMT: 1'b0, RVZiCond: 1'b1, RVZicntr: 1'b1,
        RVZihpm: 1'b1, ZKN: 1'b0, XF16: 1'b0, XF16ALT: 1'b0, XF8: 1'b0, XFVec: 1'b0,
        CvxifEn: 1'b1, SuperscalarEn: 1'b0, MmuPresent: 1'b1, DebugEn: 1'b1,
        NR_SB_ENTRIES: 8, NrCommitPorts: 2, NrIssuePorts: 1, NrWbPorts: 4, NrRgprPorts: 2,
        NUM_THREADS: 257,
        ICACHE_SET_ASSOC: 4, ICACHE_INDEX_WIDTH: 12, ICACHE_LINE_WIDTH: 128,
        DCACHE_SET_ASSOC: 8, DCACHE_INDEX_WIDTH: 12, DCACHE_LINE_WIDTH: 128,
        InstrTlbEntries: 16, DataTlbEntries: 16, NrPMPEntries: 8, FETCH_WIDTH: 32
    };

    localparam logic [31:0] ExpWord [8] = '{
        32'hCFA6_0001, 32'h4040_3829, 32'h00D0_72DF, 32'h0821_4201,
        32'h040C_0080, 32'h080C_0080, 32'h1010_0820, 32'h9B07_00D6
    };

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        rd_req_i = 1'b0;
    logic [3:0]  rd_addr_i = '0;
    logic        valid_o;
    logic [31:0] data_o;
    logic [2:0]  index_o;
    logic        last_o;
    logic        busy_o;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic        rd_err_o;

    cva6_cfg_dump #(
        .CVA6Cfg(TbCfg),
        .Version(8'd1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .index_o   (index_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .rd_req_i  (rd_req_i),
        .rd_addr_i (rd_addr_i),
        .rd_valid_o(rd_valid_o),
        .rd_data_o (rd_data_o),
        .rd_err_o  (rd_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rd_t;

    beat_t stream_q[$];
    rd_t   rd_q[$];
    beat_t exp_beat;
    rd_t   exp_rd;
    int    assertions = 0;
    int    failures = 0;
    logic  ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushDump();
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.idx  = 3'(i);
            b.data = ExpWord[i];
            b.last = (i == 7);
            stream_q.push_back(b);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr);
        rd_t r;
        rd_req_i  = 1'b1;
        rd_addr_i = addr;
        r.err     = addr[3];
        r.data    = addr[3] ? 32'h0 : ExpWord[addr[2:0]];
        rd_q.push_back(r);
    endtask

    task automatic waitIdle(input int budget, output int cycles);
        cycles = 0;
        while (busy_o && cycles < budget) begin
            tick();
            cycles++;
        end
        checkOutput("dump_finished", 32'(busy_o), 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_data"}, data_o, 32'd0);
        checkOutput({tag, "_index"}, 32'(index_o), 32'd0);
        checkOutput({tag, "_last"}, 32'(last_o), 32'd0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid_o), 32'd0);
        checkOutput({tag, "_rd_data"}, rd_data_o, 32'd0);
        checkOutput({tag, "_rd_err"}, 32'(rd_err_o), 32'd0);
    endtask

    // Monitor: every presented beat must match the head of the queue; pop only on acceptance.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o) begin
                if (stream_q.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(valid_o), 32'd0);
                end else begin
                    exp_beat = stream_q[0];
                    checkOutput("beat_index", 32'(index_o), 32'(exp_beat.idx));
                    checkOutput("beat_data", data_o, exp_beat.data);
                    checkOutput("beat_last", 32'(last_o), 32'(exp_beat.last));
                    checkOutput("beat_busy", 32'(busy_o), 32'd1);
                    if (ready_i && !abort_i) void'(stream_q.pop_front());
                end
            end
            if (rd_valid_o) begin
                if (rd_q.size() == 0) begin
                    checkOutput("unexpected_rd", 32'(rd_valid_o), 32'd0);
                end else begin
                    exp_rd = rd_q.pop_front();
                    checkOutput("rd_err", 32'(rd_err_o), 32'(exp_rd.err));
                    checkOutput("rd_data", rd_data_o, exp_rd.data);
                end
            end
        end
    end

    initial begin
        int n;
        tick();
        tick();
        checkIdleOutputs("reset");
        rst_i = 1'b0;
        tick();

        $display("[TB] single read and full address sweep");
        applyStimulus(4'd1);
        tick();
        rd_req_i = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            applyStimulus(4'(a));
            tick();
        end
        rd_req_i = 1'b0;
        tick();
        tick();

        $display("[TB] full-rate dump");
        ready_i = 1'b1;
        pushDump();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        waitIdle(20, n);
        checkOutput("dump_cycles", 32'(n), 32'd8);
        checkIdleOutputs("after_dump");

        $display("[TB] stalled dump");
        pushDump();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < 64) begin
            ready_i = ready_pat[n % 4];
            tick();
            n++;
        end
        checkOutput("stall_dump_finished", 32'(busy_o), 32'd0);
        ready_i = 1'b1;

        $display("[TB] reads during a dump, ignored restarts");
        pushDump();
        start_i = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            start_i = (a == 3 || a == 7);
            applyStimulus(4'(a));
            tick();
        end
        start_i = 1'b0;
        applyStimulus(4'd9);
        tick();
        rd_req_i = 1'b0;
        waitIdle(20, n);
        tick();
        tick();
        checkOutput("no_restart_busy", 32'(busy_o), 32'd0);

        $display("[TB] abort handling");
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checkOutput("abort_idle_busy", 32'(busy_o), 32'd0);
        ready_i = 1'b0;
        pushDump();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) tick();
        ready_i = 1'b0;
        checkOutput("abort_pre_index", 32'(index_o), 32'd3);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        stream_q.delete();
        checkOutput("abort_valid", 32'(valid_o), 32'd0);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        ready_i = 1'b1;
        pushDump();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checkOutput("restart_index", 32'(index_o), 32'd0);
        waitIdle(20, n);
        pushDump();
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        checkOutput("start_wins_busy", 32'(busy_o), 32'd1);
        waitIdle(20, n);

        $display("[TB] reset mid-dump with read in flight");
        pushDump();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        checkOutput("pre_reset_index", 32'(index_o), 32'd5);
        rst_i     = 1'b1;
        rd_req_i  = 1'b1;
        rd_addr_i = 4'd2;
        tick();
        rst_i    = 1'b0;
        rd_req_i = 1'b0;
        stream_q.delete();
        checkIdleOutputs("mid_reset");
        tick();
        tick();
        pushDump();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        waitIdle(20, n);
        checkOutput("post_reset_cycles", 32'(n), 32'd8);
        tick();
        tick();

        checkOutput("stream_queue_empty", 32'(stream_q.size()), 32'd0);
        checkOutput("read_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
